// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I/RV64I integer-subset core: fetch handshake, 31-entry register file,
// LUI/AUIPC/ALU/JAL/JALR/BEQ/BNE, illegal-instruction halt and board-debug outputs.
module rv_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic [PC_W-1:0]  pc,
    output logic [7:0]       ir_out,
    input  logic [4:0]       dbg_sel,
    output logic [XLEN-1:0]  dbg_data,
    output logic [CNT_W-1:0] retired,
    output logic             heartbeat,
    output logic             halted
);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_t            state, state_next;
    logic [31:0]       ir;
    logic [XLEN-1:0]   regs [1:31];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, pc_ext, link_val;
    logic [31:0]     imm_b32, imm_j32;
    logic [PC_W-1:0] pc_plus4, br_tgt, jal_tgt, jalr_tgt, next_pc;
    logic            slt_i, slt_r, illegal, we, fault, retire;
    logic [XLEN-1:0] wdata;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign funct3   = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign funct7   = ir[31:25];

    assign rs1_val  = (rs1 == 5'd0) ? {XLEN{1'b0}} : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? {XLEN{1'b0}} : regs[rs2];
    assign imm_i    = sext32({{20{ir[31]}}, ir[31:20]});
    assign imm_u    = sext32({ir[31:12], 12'b0});
    assign imm_b32  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j32  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // PC-relative values are formed in PC_W so they wrap modulo 2^PC_W
    assign pc_ext   = XLEN'(pc);
    assign pc_plus4 = pc + PC_W'(4);
    assign link_val = XLEN'(pc_plus4);
    assign br_tgt   = pc + PC_W'($signed(imm_b32));
    assign jal_tgt  = pc + PC_W'($signed(imm_j32));
    assign jalr_tgt = PC_W'(rs1_val + imm_i) & ~PC_W'(1);
    assign slt_i    = $signed(rs1_val) < $signed(imm_i);
    assign slt_r    = $signed(rs1_val) < $signed(rs2_val);

    // Decode and execute the instruction held in ir
    always_comb begin
        illegal = 1'b0;
        we      = 1'b0;
        wdata   = {XLEN{1'b0}};
        next_pc = pc_plus4;
        case (opcode)
            OP_LUI: begin
                we    = 1'b1;
                wdata = imm_u;
            end
            OP_AUIPC: begin
                we    = 1'b1;
                wdata = pc_ext + imm_u;
            end
            OP_IMM: begin
                we = 1'b1;
                case (funct3)
                    3'b000:  wdata = rs1_val + imm_i;
                    3'b010:  wdata = {{(XLEN-1){1'b0}}, slt_i};
                    3'b100:  wdata = rs1_val ^ imm_i;
                    3'b110:  wdata = rs1_val | imm_i;
                    3'b111:  wdata = rs1_val & imm_i;
                    default: illegal = 1'b1;
                endcase
            end
            OP_REG: begin
                we = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: wdata = rs1_val + rs2_val;
                    10'b0100000_000: wdata = rs1_val - rs2_val;
                    10'b0000000_111: wdata = rs1_val & rs2_val;
                    10'b0000000_110: wdata = rs1_val | rs2_val;
                    10'b0000000_100: wdata = rs1_val ^ rs2_val;
                    10'b0000000_010: wdata = {{(XLEN-1){1'b0}}, slt_r};
                    default:         illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                we      = 1'b1;
                wdata   = link_val;
                next_pc = jal_tgt;
            end
            OP_JALR: begin
                we      = 1'b1;
                wdata   = link_val;
                next_pc = jalr_tgt;
                illegal = (funct3 != 3'b000);
            end
            OP_BR: begin
                case (funct3)
                    3'b000:  next_pc = (rs1_val == rs2_val) ? br_tgt : pc_plus4;
                    3'b001:  next_pc = (rs1_val != rs2_val) ? br_tgt : pc_plus4;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault  = illegal | (next_pc[1:0] != 2'b00);
    assign retire = (state == EXEC) && !fault;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   state_next = imem_valid ? EXEC : FETCH;
            EXEC:    state_next = fault ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir        <= 32'h0;
            imem_req  <= 1'b0;
            retired   <= {CNT_W{1'b0}};
            heartbeat <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next == FETCH);
            halted   <= (state_next == HALT);
            if (state == FETCH && imem_valid) begin
                ir <= imem_rdata;
            end
            if (retire) begin
                pc        <= next_pc;
                retired   <= retired + CNT_W'(1);
                heartbeat <= ~heartbeat;
            end
        end
    end

    // Register file write; x0 is not stored, registers are deliberately not reset
    always_ff @(posedge clk) begin
        if (retire && we && (rd != 5'd0)) begin
            regs[rd] <= wdata;
        end
    end

    assign imem_addr = pc;
    assign ir_out    = ir[7:0];
    assign dbg_data  = (dbg_sel == 5'd0) ? {XLEN{1'b0}} : regs[dbg_sel];

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed and randomized bench for rv_multicycle_core; expected results come from an
// instruction-level model that works on mnemonic/operand tuples, not on encoded bits.
module tb_rv_multicycle_core;
    localparam int              XLEN     = 64;
    localparam int              PC_W     = 32;
    localparam int              CNT_W    = 32;
    localparam logic [PC_W-1:0] RESET_PC = 32'h0;

    typedef enum int {K_LUI, K_AUIPC, K_ADDI, K_SLTI, K_ANDI, K_ORI, K_XORI,
                      K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT,
                      K_JAL, K_JALR, K_BEQ, K_BNE} kind_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_valid = 1'b0;
    logic [31:0]      imem_rdata = 32'h0;
    logic [PC_W-1:0]  pc;
    logic [7:0]       ir_out;
    logic [4:0]       dbg_sel = 5'd0;
    logic [XLEN-1:0]  dbg_data;
    logic [CNT_W-1:0] retired;
    logic             heartbeat;
    logic             halted;

    rv_multicycle_core #(.XLEN(XLEN), .PC_W(PC_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc(pc), .ir_out(ir_out),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .retired(retired),
        .heartbeat(heartbeat), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0]  mreg [32];
    bit   [31:0]      mvalid;
    logic [PC_W-1:0]  m_pc;
    logic [CNT_W-1:0] m_ret;
    logic             m_hb;
    logic             m_halted;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [4:0] idx, output logic [XLEN-1:0] v);
        dbg_sel = idx;
        #1;
        v = dbg_data;
    endtask

    // Standard RV32I encodings
    function automatic logic [31:0] enc(input kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input int imm);
        logic [31:0] u;
        u = imm;
        case (k)
            K_LUI:   return {u[19:0], rd, 7'b0110111};
            K_AUIPC: return {u[19:0], rd, 7'b0010111};
            K_ADDI:  return {u[11:0], rs1, 3'b000, rd, 7'b0010011};
            K_SLTI:  return {u[11:0], rs1, 3'b010, rd, 7'b0010011};
            K_XORI:  return {u[11:0], rs1, 3'b100, rd, 7'b0010011};
            K_ORI:   return {u[11:0], rs1, 3'b110, rd, 7'b0010011};
            K_ANDI:  return {u[11:0], rs1, 3'b111, rd, 7'b0010011};
            K_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:   return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_AND:   return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            K_OR:    return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            K_XOR:   return {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
            K_SLT:   return {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
            K_JAL:   return {u[20], u[10:1], u[11], u[19:12], rd, 7'b1101111};
            K_JALR:  return {u[11:0], rs1, 3'b000, rd, 7'b1100111};
            K_BEQ:   return {u[12], u[10:5], rs2, rs1, 3'b000, u[4:1], u[11], 7'b1100011};
            K_BNE:   return {u[12], u[10:5], rs2, rs1, 3'b001, u[4:1], u[11], 7'b1100011};
            default: return 32'h0;
        endcase
    endfunction

    // Handshake one instruction word through the DUT and compare against the model's outcome
    task automatic step(input logic [31:0] instr, input int stall, input logic flt,
                        input logic [PC_W-1:0] npc, input logic we, input logic [4:0] rd,
                        input logic [XLEN-1:0] res);
        logic [XLEN-1:0] v;
        chk("req_fetch", imem_req, 1'b1);
        chk("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < stall; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            chk("req_stall", imem_req, 1'b1);
            chk("pc_stall", pc, m_pc);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        chk("ir_out", ir_out, instr[7:0]);
        chk("req_exec", imem_req, 1'b0);
        chk("pc_exec", pc, m_pc);
        imem_valid = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_valid = 1'b0;
        if (!flt) begin
            if (we && rd != 5'd0) begin
                mreg[rd]   = res;
                mvalid[rd] = 1'b1;
            end
            m_pc  = npc;
            m_ret = m_ret + 32'd1;
            m_hb  = ~m_hb;
        end else begin
            m_halted = 1'b1;
        end
        chk("pc", pc, m_pc);
        chk("retired", retired, m_ret);
        chk("heartbeat", heartbeat, m_hb);
        chk("halted", halted, m_halted);
        chk("req_after", imem_req, !m_halted);
        if (rd == 5'd0) begin
            peek(5'd0, v);
            chk("dbg_x0", v, 64'h0);
        end else if (mvalid[rd]) begin
            peek(rd, v);
            chk("dbg_rd", v, mreg[rd]);
        end else begin
            dbg_sel = 5'd0;
        end
    endtask

    // Instruction-level reference: semantics from mnemonic + operands
    task automatic run(input kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input int imm, input int stall);
        logic [XLEN-1:0] a, b, res, ix, s;
        logic [PC_W-1:0] npc;
        logic            we;
        int              t;
        a   = (rs1 == 5'd0) ? 64'h0 : mreg[rs1];
        b   = (rs2 == 5'd0) ? 64'h0 : mreg[rs2];
        ix  = XLEN'(imm);
        t   = imm << 12;
        npc = m_pc + 32'd4;
        we  = 1'b1;
        res = 64'h0;
        case (k)
            K_LUI:   res = XLEN'(t);
            K_AUIPC: res = XLEN'(m_pc) + XLEN'(t);
            K_ADDI:  res = a + ix;
            K_SLTI:  res = ($signed(a) < $signed(ix)) ? 64'd1 : 64'd0;
            K_ANDI:  res = a & ix;
            K_ORI:   res = a | ix;
            K_XORI:  res = a ^ ix;
            K_ADD:   res = a + b;
            K_SUB:   res = a - b;
            K_AND:   res = a & b;
            K_OR:    res = a | b;
            K_XOR:   res = a ^ b;
            K_SLT:   res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            K_JAL: begin
                res = XLEN'(npc);
                npc = m_pc + PC_W'(imm);
            end
            K_JALR: begin
                res = XLEN'(npc);
                s   = a + ix;
                npc = PC_W'(s) & ~32'h1;
            end
            K_BEQ: begin
                we = 1'b0;
                if (a == b) npc = m_pc + PC_W'(imm);
            end
            K_BNE: begin
                we = 1'b0;
                if (a != b) npc = m_pc + PC_W'(imm);
            end
            default: we = 1'b0;
        endcase
        step(enc(k, rd, rs1, rs2, imm), stall, (npc[1:0] != 2'b00), npc, we,
             (we ? rd : 5'd0), res);
    endtask

    task automatic release_reset();
        reset    = 1'b0;
        m_pc     = RESET_PC;
        m_ret    = 32'd0;
        m_hb     = 1'b0;
        m_halted = 1'b0;
        chk("req_idle", imem_req, 1'b0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_ir_out"}, ir_out, 8'h0);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_retired"}, retired, 32'd0);
        chk({tag, "_hb"}, heartbeat, 1'b0);
        chk({tag, "_halted"}, halted, 1'b0);
    endtask

    initial begin
        logic [XLEN-1:0] v, old5;
        logic [PC_W-1:0] hold_pc;
        kind_t           k;
        logic [4:0]      rd, rs1, rs2;
        int              imm;
        mvalid = 32'h0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        release_reset();

        // Directed program
        run(K_LUI, 5'd1, 5'd0, 5'd0, 32'h12345, 0);
        peek(5'd1, v);
        chk("lui_x1", v, 64'h0000_0000_1234_5000);
        chk("lui_pc", pc, 32'h4);
        chk("lui_ret", retired, 32'd1);
        chk("lui_hb", heartbeat, 1'b1);
        run(K_LUI, 5'd2, 5'd0, 5'd0, 32'h80000, 1);
        peek(5'd2, v);
        chk("lui_x2", v, 64'hFFFF_FFFF_8000_0000);
        run(K_ADDI, 5'd3, 5'd0, 5'd0, -1, 0);
        run(K_ADD, 5'd4, 5'd3, 5'd3, 0, 2);
        peek(5'd4, v);
        chk("add_wrap", v, 64'hFFFF_FFFF_FFFF_FFFE);
        run(K_BNE, 5'd0, 5'd0, 5'd0, 8, 0);
        chk("bne_pc", pc, 32'h14);
        run(K_JAL, 5'd0, 5'd0, 5'd0, -4, 0);
        run(K_BEQ, 5'd0, 5'd0, 5'd0, 8, 0);
        chk("beq_pc", pc, 32'h18);
        run(K_ADDI, 5'd0, 5'd0, 5'd0, 5, 0);
        chk("x0_ret", retired, 32'd8);
        run(K_BEQ, 5'd0, 5'd0, 5'd0, 32'h14, 0);
        run(K_JAL, 5'd1, 5'd0, 5'd0, 32'h20, 0);
        peek(5'd1, v);
        chk("jal_link", v, 64'h34);
        chk("jal_pc", pc, 32'h50);
        run(K_ADDI, 5'd5, 5'd0, 5'd0, 32'h55, 3);

        // Give every register a known value, then run a random instruction mix
        for (int i = 1; i < 32; i++) begin
            if ($urandom_range(0, 1) == 0)
                run(K_LUI, 5'(i), 5'd0, 5'd0, int'($urandom_range(0, 20'hFFFFF)), int'($urandom_range(0, 2)));
            else
                run(K_ADDI, 5'(i), 5'd0, 5'd0, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 2)));
        end
        for (int n = 0; n < 200; n++) begin
            k   = kind_t'($urandom_range(0, 16));
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            case (k)
                K_LUI, K_AUIPC:      imm = int'($urandom_range(0, 20'hFFFFF));
                K_JAL, K_BEQ, K_BNE: imm = (int'($urandom_range(0, 64)) - 32) * 4;
                K_JALR: begin
                    rs1 = 5'd0;
                    imm = (int'($urandom_range(0, 64)) - 32) * 4;
                end
                default:             imm = int'($urandom_range(0, 4095)) - 2048;
            endcase
            run(k, rd, rs1, rs2, imm, int'($urandom_range(0, 3)));
        end

        // Reset while an instruction is in EXEC: nothing retires or writes
        old5       = mreg[5];
        imem_valid = 1'b1;
        imem_rdata = enc(K_ADDI, 5'd5, 5'd5, 5'd0, 1);
        @(negedge clk);
        imem_valid = 1'b0;
        chk("req_exec_cut", imem_req, 1'b0);
        reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        release_reset();
        peek(5'd5, v);
        chk("x5_not_written", v, old5);
        chk("refetch_addr", imem_addr, RESET_PC);

        // Illegal all-zero word halts and absorbs
        run(K_ADDI, 5'd6, 5'd0, 5'd0, 7, 0);
        hold_pc = m_pc;
        step(32'h0000_0000, 1, 1'b1, m_pc, 1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'b1;
            imem_rdata = enc(K_ADDI, 5'd6, 5'd0, 5'd0, 9);
            @(negedge clk);
            chk("halt_hold", halted, 1'b1);
            chk("halt_req", imem_req, 1'b0);
            chk("halt_pc", pc, hold_pc);
            chk("halt_ret", retired, 32'd1);
        end
        imem_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst2");
        release_reset();

        // JALR to a misaligned target halts without writing the link register
        run(K_JALR, 5'd7, 5'd0, 5'd0, 2, 0);
        chk("jalr_halt", halted, 1'b1);
        chk("jalr_pc", pc, RESET_PC);
        reset = 1'b1;
        @(negedge clk);
        release_reset();

        // Unsupported encodings: MUL (funct7=1) and SLTIU
        step({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011}, 0, 1'b1, m_pc, 1'b0, 5'd8, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        release_reset();
        step({12'h001, 5'd1, 3'b011, 5'd9, 7'b0010011}, 0, 1'b1, m_pc, 1'b0, 5'd9, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_multicycle_core.md
# rv_multicycle_core

Parametrised successor to the board-level single-instruction LUI core. It is a multi-cycle RV32I/RV64I integer subset core with an instruction-fetch handshake, a full register file, control flow, and an illegal-instruction halt. It also provides board-debug outputs: heartbeat, register peek, low IR byte and retire count. It sits between the on-board instruction ROM/BRAM and the LED/UART debug logic.

## Interface
- `XLEN`, default 64: register/datapath width; legal values 32 or 64.
- `PC_W`, default 32: program-counter width; all PC arithmetic is modulo 2^PC_W.
- `RESET_PC`, default 0: PC value after reset; must be 4-byte aligned.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request, registered.
- `imem_addr` out PC_W: fetch address; equals `pc` whenever `imem_req`=1.
- `imem_valid` in 1: instruction word valid; sampled only while `imem_req`=1.
- `imem_rdata` in 32: instruction word.
- `pc` out PC_W: address of the current instruction.
- `ir_out` out 8: `ir[7:0]`.
- `dbg_sel` in 5: register index to peek.
- `dbg_data` out XLEN: combinational read of `x[dbg_sel]`; reads 0 when `dbg_sel`=0.
- `retired` out CNT_W: count of retired instructions; wraps.
- `heartbeat` out 1: toggles on every retire.
- `halted` out 1: high once an illegal instruction or misaligned target has been seen.

## Operation
- Supported instructions:
  - LUI, AUIPC.
  - ADDI, SLTI, ANDI, ORI, XORI.
  - ADD, SUB, AND, OR, XOR, SLT.
  - JAL, JALR, BEQ, BNE.
- Any other opcode/funct3/funct7 combination is illegal.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE: entered on reset. Next cycle goes to FETCH.
  - FETCH: `imem_req`=1. On `imem_valid`=1, `ir`<=`imem_rdata` and the FSM moves to EXEC; otherwise it stays in FETCH.
  - EXEC: `imem_req`=0. Write `rd`, update `pc`, increment `retired`, toggle `heartbeat`, then go to FETCH. On an illegal instruction or misaligned target, go to HALT with no writes.
  - HALT: `halted`=1, `imem_req`=0. Absorbing; only `reset` leaves it.
- Register rules:
  - x0 reads 0. Writes to x0 are discarded; the instruction still retires.
  - Registers are not reset and read X until written. The bench must not depend on their reset state.
- Immediates are sign-extended to XLEN; LUI/AUIPC use `{imm[31:12],12'b0}` sign-extended.
- All arithmetic is modulo 2^XLEN.
- SLT/SLTI compare signed and write 0 or 1.
- AUIPC and link values are zero-extended PC_W to XLEN.
- Next PC:
  - Default: `pc`+4.
  - JAL / taken branch: `pc`+imm.
  - JALR: (`rs1`+imm) with bit0 cleared.
  - The result is truncated to PC_W. If bits[1:0] are not 0 → HALT, and `pc` holds the faulting instruction.
- Registers are read in EXEC, so `rs1`=`rd` of the previous instruction sees the new value (no hazards).

## Timing
- Reset values:
  - `pc`=RESET_PC.
  - `ir`=0, `ir_out`=0.
  - `imem_req`=0.
  - `retired`=0.
  - `heartbeat`=0.
  - `halted`=0.
- First `imem_req`=1 occurs in the 2nd cycle after reset deassertion (IDLE → FETCH).
- Per instruction: 1 + N cycles, where N ≥ 1 is the number of FETCH cycles until `imem_valid`. The minimum is 2 cycles/instruction.
- `pc`, `retired`, `heartbeat` and the register write all update on the same edge that leaves EXEC.
- `ir_out` updates on the edge that leaves FETCH.
- `imem_valid` outside FETCH is ignored.
- `reset` asserted in any state forces all outputs to their reset values asynchronously. No partial register write may occur; an EXEC cut by reset does not retire.

## Test plan
- LUI x1,0x12345 at pc 0 with `imem_valid` same cycle → x1=0x0000000012345000, `pc`=4, `retired`=1, `heartbeat`=1, 2 cycles elapsed.
- LUI x2,0x80000 (XLEN=64) → x2=0xFFFFFFFF80000000. With XLEN=32 → x2=0x80000000.
- ADDI x3,x0,-1; ADD x4,x3,x3 → x4=all-ones minus 1 (wrap). ADDI x0,x0,5 → `dbg_sel`=0 reads 0, `retired` still increments.
- BEQ x0,x0,+8 at pc 0x10 → `pc`=0x18. BNE x0,x0,+8 → `pc`=0x14. JAL x1,+0x20 at 0x30 → x1=0x34, `pc`=0x50.
- `imem_valid` held low 3 cycles → `imem_req` stays 1, `pc` stable, instruction retires on cycle 5. Word 0x00000000 → `halted`=1, `imem_req`=0, `pc` unchanged; JALR to target 0x2 → HALT.
- Assert `reset` mid-EXEC → outputs return to reset values immediately, `retired`=0, destination register not written. After release, fetch restarts at RESET_PC on cycle 2.
